fp_mult_rr_scheduler: RTL

- Shares one pipelined floating-point multiplier (Task6_Mult_top-class, fixed latency, one issue per cycle, no stall) between NREQ requesters.
- Arbitration is round-robin. The block registers the winning operands into the multiplier, tracks in-flight operations with a tag pipeline, and returns each product with the requester ID.
- It sits between the expression datapaths (0.5*x, x^2, x/128 and the cosine scaling stages), so fewer multiplier instances are needed.

---
 rtl/fp_mult_rr_scheduler_if.sv | 25 ++
 rtl/fp_mult_rr_scheduler.sv | 111 +++++++++++
 2 files changed

// File: rtl/fp_mult_rr_scheduler_if.sv
// Requester/response bundle for fp_mult_rr_scheduler: packed per-requester operands,
// one-hot grant back to the requesters, and the tagged product stream.
interface fp_mult_rr_scheduler_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*32-1:0] req_a;
    logic [NREQ*32-1:0] req_b;
    logic [NREQ-1:0]    req_ready;
    logic               rsp_valid;
    logic [IDW-1:0]     rsp_id;
    logic [31:0]        rsp_data;

    // master = the requester side, slave = the scheduler
    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/fp_mult_rr_scheduler.sv
// Round-robin sharing of one fixed-latency pipelined FP multiplier among NREQ requesters.
// Optional per-requester grant counters are enabled with `define FP_MULT_SCHED_PERF_EN.
module fp_mult_rr_scheduler #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int LAT  = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    fp_mult_rr_scheduler_if.slave bus,
    output logic [31:0]          mul_dataa,
    output logic [31:0]          mul_datab,
    input  logic [31:0]          mul_result,
    output logic                 busy
`ifdef FP_MULT_SCHED_PERF_EN
    ,
    input  logic [IDW-1:0]       perf_sel,
    input  logic                 perf_clr,
    output logic [15:0]          perf_count
`endif
);

    logic [IDW-1:0]  ptr;
    logic            grant;
    logic [IDW-1:0]  g;
    logic [IDW-1:0]  idx;
    logic [NREQ-1:0] ready;

    logic [LAT:0]    tag_valid;
    logic [IDW-1:0]  tag_id [LAT+1];

    // Scan from ptr upward with wrap; walking offsets high-to-low lets the
    // closest requester to ptr overwrite any farther candidate.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        grant = 1'b0;
        g     = '0;
        idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = IDW'((int'(ptr) + k) % NREQ);
            if (bus.req_valid[idx]) begin
                grant = 1'b1;
                g     = idx;
            end
        end
    end

    always_comb begin
        ready = '0;
        if (grant && reset_n) ready[g] = 1'b1;
    end

    assign bus.req_ready = ready;

    // NOTE: state is written with non-blocking assignments so every register
    // samples the pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr       <= '0;
            mul_dataa <= '0;
            mul_datab <= '0;
        end else if (grant) begin
            ptr       <= (g == IDW'(NREQ - 1)) ? '0 : g + 1'b1;
            mul_dataa <= bus.req_a[32*g +: 32];
            mul_datab <= bus.req_b[32*g +: 32];
        end else begin
            mul_dataa <= '0;
            mul_datab <= '0;
        end
    end

    // Tag pipeline mirrors the multiplier: stage LAT lines up with mul_result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_valid <= '0;
            // NOTE: the id array is small and feeds rsp_id, so it is reset
            // explicitly rather than left as uninitialised storage.
            for (int s = 0; s <= LAT; s++) tag_id[s] <= '0;
        end else begin
            tag_valid <= {tag_valid[LAT-1:0], grant};
            tag_id[0] <= g;
            for (int s = 1; s <= LAT; s++) tag_id[s] <= tag_id[s-1];
        end
    end

    assign bus.rsp_valid = tag_valid[LAT];
    assign bus.rsp_id    = tag_valid[LAT] ? tag_id[LAT] : '0;
    assign bus.rsp_data  = mul_result;
    assign busy          = |tag_valid;

`ifdef FP_MULT_SCHED_PERF_EN
    logic [15:0] perf_cnt [NREQ];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREQ; i++) perf_cnt[i] <= '0;
            perf_count <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (perf_clr)
                    perf_cnt[i] <= '0;
                else if (grant && (g == IDW'(i)) && (perf_cnt[i] != 16'hFFFF))
                    perf_cnt[i] <= perf_cnt[i] + 16'd1;
            end
            // Clear also zeroes the read port so the cleared value shows next cycle.
            perf_count <= perf_clr ? 16'd0 : perf_cnt[perf_sel];
        end
    end
`endif

endmodule
